// File: rtl/object_tracker.sv
// Per-channel mask centroid tracker: accumulates masked pixel coordinates per frame and
// divides them with one shared restoring divider. Define OBJECT_TRACKER_SMOOTH_EN for one-pole output smoothing.
module object_tracker #(
  parameter int NUM_CH    = 2,
  parameter int H_WIDTH   = 11,
  parameter int V_WIDTH   = 10,
  parameter int MIN_COUNT = 16
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [H_WIDTH-1:0]          x_in,
  input  logic [V_WIDTH-1:0]          y_in,
  input  logic [NUM_CH-1:0]           mask_in,
  input  logic                        valid_in,
  input  logic                        frame_start_in,
  output logic [NUM_CH*H_WIDTH-1:0]   x_out,
  output logic [NUM_CH*V_WIDTH-1:0]   y_out,
  output logic [NUM_CH-1:0]           found_out,
  output logic                        valid_out,
  output logic                        busy_out,
  output logic                        overrun_out
);

  localparam int SUM_W = 2*H_WIDTH + V_WIDTH;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W = $clog2(SUM_W) + 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SUM_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, NEXT, DONE} state_t;

  state_t state_q, state_d;

  logic [SUM_W-1:0]   acc_x_q [NUM_CH];
  logic [SUM_W-1:0]   acc_x_d [NUM_CH];
  logic [SUM_W-1:0]   acc_y_q [NUM_CH];
  logic [SUM_W-1:0]   acc_y_d [NUM_CH];
  logic [SUM_W-1:0]   acc_n_q [NUM_CH];
  logic [SUM_W-1:0]   acc_n_d [NUM_CH];
  logic [SUM_W-1:0]   shd_x_q [NUM_CH];
  logic [SUM_W-1:0]   shd_x_d [NUM_CH];
  logic [SUM_W-1:0]   shd_y_q [NUM_CH];
  logic [SUM_W-1:0]   shd_y_d [NUM_CH];
  logic [SUM_W-1:0]   shd_n_q [NUM_CH];
  logic [SUM_W-1:0]   shd_n_d [NUM_CH];
  logic [H_WIDTH-1:0] x_q     [NUM_CH];
  logic [H_WIDTH-1:0] x_d     [NUM_CH];
  logic [V_WIDTH-1:0] y_q     [NUM_CH];
  logic [V_WIDTH-1:0] y_d     [NUM_CH];

  logic [NUM_CH-1:0] found_q, found_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [SUM_W-1:0]  quo_q, quo_d;
  logic [SUM_W-1:0]  rem_q, rem_d;
  logic [SUM_W-1:0]  dvs_q, dvs_d;
  logic [BIT_W-1:0]  bit_q, bit_d;

  logic [SUM_W:0]     rem_shift;
  logic               rem_ge;
  logic [SUM_W-1:0]   rem_next;
  logic [SUM_W-1:0]   quo_next;
  logic [H_WIDTH-1:0] x_raw, x_wr;
  logic [V_WIDTH-1:0] y_raw, y_wr;
  logic               load_skip;
  logic               div_last;

  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SUM_W] ? '1 : s[SUM_W-1:0];
  endfunction

  // Live accumulators; the frame_start cycle clears them and drops its own pixel.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      acc_x_d[c] = acc_x_q[c];
      acc_y_d[c] = acc_y_q[c];
      acc_n_d[c] = acc_n_q[c];
      if (frame_start_in) begin
        acc_x_d[c] = '0;
        acc_y_d[c] = '0;
        acc_n_d[c] = '0;
      end else if (valid_in && mask_in[c]) begin
        acc_x_d[c] = sat_add(acc_x_q[c], SUM_W'(x_in));
        acc_y_d[c] = sat_add(acc_y_q[c], SUM_W'(y_in));
        acc_n_d[c] = sat_add(acc_n_q[c], SUM_W'(1));
      end
    end
  end

  // One restoring-division step: the quotient shifts in where the dividend shifts out.
  always_comb begin
    rem_shift = {rem_q, quo_q[SUM_W-1]};
    rem_ge    = rem_shift[SUM_W] || (rem_shift[SUM_W-1:0] >= dvs_q);
    rem_next  = rem_ge ? (rem_shift[SUM_W-1:0] - dvs_q) : rem_shift[SUM_W-1:0];
    quo_next  = {quo_q[SUM_W-2:0], rem_ge};
    load_skip = shd_n_q[ch_q] < SUM_W'(MIN_COUNT);
    div_last  = (bit_q == LAST_BIT);
  end

  always_comb begin
    x_raw = quo_next[H_WIDTH-1:0];
    y_raw = quo_next[V_WIDTH-1:0];
`ifdef OBJECT_TRACKER_SMOOTH_EN
    begin
      logic [H_WIDTH:0] x_avg;
      logic [V_WIDTH:0] y_avg;
      x_avg = {1'b0, x_q[ch_q]} + {1'b0, x_raw};
      y_avg = {1'b0, y_q[ch_q]} + {1'b0, y_raw};
      x_wr  = found_q[ch_q] ? H_WIDTH'(x_avg >> 1) : x_raw;
      y_wr  = found_q[ch_q] ? V_WIDTH'(y_avg >> 1) : y_raw;
    end
`else
    x_wr = x_raw;
    y_wr = y_raw;
`endif
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start_in) state_d = LOAD;
      LOAD:    state_d = load_skip ? NEXT : DIV_X;
      DIV_X:   if (div_last) state_d = DIV_Y;
      DIV_Y:   if (div_last) state_d = NEXT;
      NEXT:    state_d = (ch_q == LAST_CH) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output register updates driven by the current state.
  always_comb begin
    shd_x_d   = shd_x_q;
    shd_y_d   = shd_y_q;
    shd_n_d   = shd_n_q;
    x_d       = x_q;
    y_d       = y_q;
    found_d   = found_q;
    ch_d      = ch_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    bit_d     = bit_q;
    valid_d   = (state_q == DONE);
    overrun_d = overrun_q || (frame_start_in && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (frame_start_in) begin
          shd_x_d = acc_x_q;
          shd_y_d = acc_y_q;
          shd_n_d = acc_n_q;
          ch_d    = '0;
        end
      end
      LOAD: begin
        quo_d = shd_x_q[ch_q];
        rem_d = '0;
        dvs_d = shd_n_q[ch_q];
        bit_d = '0;
        if (load_skip) found_d[ch_q] = 1'b0;
      end
      DIV_X: begin
        quo_d = quo_next;
        rem_d = rem_next;
        bit_d = bit_q + BIT_W'(1);
        if (div_last) begin
          x_d[ch_q] = x_wr;
          quo_d     = shd_y_q[ch_q];
          rem_d     = '0;
          bit_d     = '0;
        end
      end
      DIV_Y: begin
        quo_d = quo_next;
        rem_d = rem_next;
        bit_d = bit_q + BIT_W'(1);
        if (div_last) begin
          y_d[ch_q]     = y_wr;
          found_d[ch_q] = 1'b1;
        end
      end
      NEXT: begin
        if (ch_q != LAST_CH) ch_d = ch_q + CH_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_x_q[c] <= '0;
        acc_y_q[c] <= '0;
        acc_n_q[c] <= '0;
        shd_x_q[c] <= '0;
        shd_y_q[c] <= '0;
        shd_n_q[c] <= '0;
        x_q[c]     <= '0;
        y_q[c]     <= '0;
      end
      found_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ch_q      <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      bit_q     <= '0;
    end else begin
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      acc_n_q   <= acc_n_d;
      shd_x_q   <= shd_x_d;
      shd_y_q   <= shd_y_d;
      shd_n_q   <= shd_n_d;
      x_q       <= x_d;
      y_q       <= y_d;
      found_q   <= found_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ch_q      <= ch_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      bit_q     <= bit_d;
    end
  end

  always_comb begin
    x_out = '0;
    y_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      x_out[c*H_WIDTH +: H_WIDTH] = x_q[c];
      y_out[c*V_WIDTH +: V_WIDTH] = y_q[c];
    end
    found_out   = found_q;
    valid_out   = valid_q;
    overrun_out = overrun_q;
    busy_out    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_object_tracker.sv
// Directed self-checking bench for object_tracker (NUM_CH=2, MIN_COUNT=4).
// Expected values are hand-computed; smoothing expectations follow OBJECT_TRACKER_SMOOTH_EN.
module tb_object_tracker;

`ifdef OBJECT_TRACKER_SMOOTH_EN
   localparam bit SMOOTH = 1'b1;
`else
   localparam bit SMOOTH = 1'b0;
`endif

   logic        clkIn;
   logic        rstIn;
   logic [10:0] xIn;
   logic [9:0]  yIn;
   logic [1:0]  maskIn;
   logic        validIn;
   logic        frameStartIn;
   logic [21:0] xOut;
   logic [19:0] yOut;
   logic [1:0]  foundOut;
   logic        validOut;
   logic        busyOut;
   logic        overrunOut;

   int   compareCount;
   int   mismatchCount;
   int   latency;
   int   validPulses;
   logic busyAtStart;

   object_tracker #(
      .NUM_CH    (2),
      .H_WIDTH   (11),
      .V_WIDTH   (10),
      .MIN_COUNT (4)
   ) dut (
      .clk_in         (clkIn),
      .rst_in         (rstIn),
      .x_in           (xIn),
      .y_in           (yIn),
      .mask_in        (maskIn),
      .valid_in       (validIn),
      .frame_start_in (frameStartIn),
      .x_out          (xOut),
      .y_out          (yOut),
      .found_out      (foundOut),
      .valid_out      (validOut),
      .busy_out       (busyOut),
      .overrun_out    (overrunOut)
   );

   // Free-running 100 MHz clock
   initial clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   // Hard stop in case a wait loop is ever broken
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if the observed value differs
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Drive one input cycle just after a rising edge; it is sampled on the next edge
   task automatic applyStimulus(input int x, input int y, input logic [1:0] mask, input logic fs);
      @(posedge clkIn);
      #1;
      xIn          = x[10:0];
      yIn          = y[9:0];
      maskIn       = mask;
      validIn      = (mask != 2'b00);
      frameStartIn = fs;
   endtask

   // Count edges from the one sampling frame_start until valid_out is seen
   task automatic waitValid(output int lat);
      lat = 0;
      for (int k = 1; k <= 400; k++) begin
         @(posedge clkIn);
         #1;
         frameStartIn = 1'b0;
         validIn      = 1'b0;
         maskIn       = 2'b00;
         if (k == 1) busyAtStart = busyOut;
         if (validOut) begin
            lat = k;
            break;
         end
      end
   endtask

   // Confirm valid_out drops after exactly one cycle
   task automatic checkPulseEnd(input string tag);
      @(posedge clkIn);
      #1;
      checkOutput(tag, validOut, 1'b0);
   endtask

   initial begin
      compareCount  = 0;
      mismatchCount = 0;
      rstIn         = 1'b0;
      xIn           = '0;
      yIn           = '0;
      maskIn        = '0;
      validIn       = 1'b0;
      frameStartIn  = 1'b0;

      // Reset state
      repeat (3) @(posedge clkIn);
      #1;
      checkOutput("rst_x_out", xOut, 0);
      checkOutput("rst_y_out", yOut, 0);
      checkOutput("rst_found", foundOut, 0);
      checkOutput("rst_valid", validOut, 0);
      checkOutput("rst_busy", busyOut, 0);
      checkOutput("rst_overrun", overrunOut, 0);
      rstIn = 1'b1;

      // Frame A: ch0 x=100..103, y=50 -> x0=101 (406/4), y0=50, ch1 skipped
      for (int x = 100; x <= 103; x++) applyStimulus(x, 50, 2'b01, 1'b0);
      applyStimulus(0, 0, 2'b00, 1'b1);
      waitValid(latency);
      checkOutput("a_busy_after_fs", busyAtStart, 1'b1);
      checkOutput("a_latency", latency, 70);
      checkOutput("a_x0", xOut[10:0], 101);
      checkOutput("a_y0", yOut[9:0], 50);
      checkOutput("a_x1", xOut[21:11], 0);
      checkOutput("a_y1", yOut[19:10], 0);
      checkOutput("a_found", foundOut, 2'b01);
      checkOutput("a_overrun", overrunOut, 0);
      checkPulseEnd("a_valid_width");
      checkOutput("a_idle_busy", busyOut, 0);

      // Frame B: ch1 20x20 square x=490..509, y=290..309 -> (499,299); ch0 only 3 hits
      for (int y = 290; y <= 309; y++)
         for (int x = 490; x <= 509; x++) applyStimulus(x, y, 2'b10, 1'b0);
      for (int x = 10; x <= 12; x++) applyStimulus(x, 5, 2'b01, 1'b0);
      applyStimulus(0, 0, 2'b00, 1'b1);
      waitValid(latency);
      checkOutput("b_latency", latency, 70);
      checkOutput("b_x1", xOut[21:11], 499);
      checkOutput("b_y1", yOut[19:10], 299);
      checkOutput("b_found", foundOut, 2'b10);
      checkOutput("b_x0_hold", xOut[10:0], 101);
      checkOutput("b_y0_hold", yOut[9:0], 50);

      // Frame C: both channels found, second frame_start 10 cycles into the pass
      for (int i = 0; i < 4; i++) applyStimulus(200, 60, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(400, 100, 2'b10, 1'b0);
      applyStimulus(0, 0, 2'b00, 1'b1);
      latency     = 0;
      validPulses = 0;
      for (int k = 1; k <= 170; k++) begin
         @(posedge clkIn);
         #1;
         if (validOut) begin
            validPulses++;
            if (latency == 0) latency = k;
         end
         xIn          = '0;
         yIn          = '0;
         maskIn       = 2'b00;
         validIn      = 1'b0;
         frameStartIn = 1'b0;
         if (k <= 4) begin
            xIn = 11'd50; yIn = 10'd10; maskIn = 2'b01; validIn = 1'b1;
         end else if (k == 10) begin
            frameStartIn = 1'b1;
         end else if (k >= 11 && k <= 14) begin
            xIn = 11'd300; yIn = 10'd70; maskIn = 2'b01; validIn = 1'b1;
         end
      end
      checkOutput("c_latency", latency, 134);
      checkOutput("c_valid_pulses", validPulses, 1);
      checkOutput("c_overrun", overrunOut, 1'b1);
      checkOutput("c_x0", xOut[10:0], 200);
      checkOutput("c_y0", yOut[9:0], 60);
      checkOutput("c_x1", xOut[21:11], SMOOTH ? 449 : 400);
      checkOutput("c_y1", yOut[19:10], SMOOTH ? 199 : 100);
      checkOutput("c_found", foundOut, 2'b11);

      // Frame E holds only the pixels after the overrunning pulse
      applyStimulus(0, 0, 2'b00, 1'b1);
      waitValid(latency);
      checkOutput("e_latency", latency, 70);
      checkOutput("e_x0", xOut[10:0], SMOOTH ? 250 : 300);
      checkOutput("e_y0", yOut[9:0], SMOOTH ? 65 : 70);
      checkOutput("e_found", foundOut, 2'b01);
      checkOutput("e_x1_hold", xOut[21:11], SMOOTH ? 449 : 400);
      checkOutput("e_overrun_sticky", overrunOut, 1'b1);

      // Frame D: reset asserted while the divider is in DIV_Y of channel 0
      for (int i = 0; i < 4; i++) applyStimulus(20, 20, 2'b01, 1'b0);
      applyStimulus(0, 0, 2'b00, 1'b1);
      @(posedge clkIn);
      #1;
      frameStartIn = 1'b0;
      repeat (44) @(posedge clkIn);
      #1;
      checkOutput("d_busy_before_rst", busyOut, 1'b1);
      #1;
      rstIn = 1'b0;
      #1;
      checkOutput("d_rst_x_out", xOut, 0);
      checkOutput("d_rst_y_out", yOut, 0);
      checkOutput("d_rst_found", foundOut, 0);
      checkOutput("d_rst_busy", busyOut, 0);
      checkOutput("d_rst_overrun", overrunOut, 0);
      checkOutput("d_rst_valid", validOut, 0);
      @(posedge clkIn);
      #1;
      rstIn       = 1'b1;
      validPulses = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clkIn);
         #1;
         if (validOut) validPulses++;
      end
      checkOutput("d_no_valid_after_rst", validPulses, 0);
      checkOutput("d_idle_after_rst", busyOut, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
